// File: rtl/gomoku_pkg.sv
// gomoku_pkg: shared states, sprite geometry and sprite masks for the move sequencer.
package gomoku_pkg;
   localparam int SPRITE_DIM = 15;
   localparam int BANNER_W   = 68;
   localparam int BANNER_H   = 5;
   localparam int BOARD_DIM  = 7;

   typedef enum logic [2:0] {
      S_IDLE, S_COMMIT, S_SETTLE, S_DRAW, S_TOGGLE, S_WAIT, S_BANNER, S_OVER
   } state_t;

   // Filled disc, row widths 7..15..7 pixels, symmetric about column 7.
   localparam logic [SPRITE_DIM-1:0][SPRITE_DIM-1:0] CIRCLE = {
      15'h07F0, 15'h0FF8, 15'h1FFC, 15'h3FFE, 15'h3FFE,
      15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF,
      15'h3FFE, 15'h3FFE, 15'h1FFC, 15'h0FF8, 15'h07F0
   };

   localparam logic [BANNER_H-1:0][BANNER_W-1:0] WINTXT = {
      68'hF_FFFF_FFFF_FFFF_FFFF,
      68'h8_0000_0000_0000_0001,
      68'h8_0000_0000_0000_0001,
      68'h8_0000_0000_0000_0001,
      68'hF_FFFF_FFFF_FFFF_FFFF
   };
endpackage

// File: rtl/move_sequencer_sprite_rom.sv
// sprite_rom: combinational lookup of the stone disc (sel=0) or the win banner (sel=1).
module sprite_rom
   import gomoku_pkg::*;
(
   input  logic       sel,
   input  logic [3:0] row,
   input  logic [6:0] col,
   output logic       pix
);
   assign pix = sel ? WINTXT[row[2:0]][col] : CIRCLE[row][col[3:0]];
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: turn controller between cursor, board7 and the VGA plot port.
// Validates a placement, strobes go, draws the stone, toggles the player and shows the win banner.
module move_sequencer
   import gomoku_pkg::*;
#(
   parameter int BOARD_X0  = 24,
   parameter int BOARD_Y0  = 4,
   parameter int PITCH     = 16,
   parameter int WIN_DELAY = 250,
   parameter int TXT_X0    = 2,
   parameter int TXT_Y0    = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       place_req,
   input  logic [2:0] cur_x,
   input  logic [2:0] cur_y,
   input  logic       cell_occupied,
   input  logic       win_state,
   input  logic       win_color,
   output logic       go,
   output logic       color,
   output logic       reject,
   output logic       plot,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       busy
);
   state_t     state_q, state_d;
   logic       place_req_q, req_q, req_d;
   logic [2:0] lx_q, lx_d, ly_q, ly_d;
   logic       lc_q, lc_d, color_q, color_d;
   logic [6:0] cx_q, cx_d;
   logic [3:0] cy_q, cy_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] vx_q;
   logic [6:0] vy_q;
   logic [2:0] vc_q;
   logic       pix;

   sprite_rom u_rom (.sel(state_q == S_BANNER), .row(cy_q), .col(cx_q), .pix(pix));

   assign req_d = place_req & ~place_req_q;
   assign busy  = (state_q != S_IDLE) && (state_q != S_OVER);
   assign color = color_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= S_IDLE;
         place_req_q <= 1'b0;
         req_q       <= 1'b0;
         lx_q        <= '0;
         ly_q        <= '0;
         lc_q        <= 1'b0;
         color_q     <= 1'b0;
         cx_q        <= '0;
         cy_q        <= '0;
         cnt_q       <= '0;
         vx_q        <= '0;
         vy_q        <= '0;
         vc_q        <= '0;
      end else begin
         state_q     <= state_d;
         place_req_q <= place_req;
         req_q       <= req_d;
         lx_q        <= lx_d;
         ly_q        <= ly_d;
         lc_q        <= lc_d;
         color_q     <= color_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         cnt_q       <= cnt_d;
         vx_q        <= vga_x;
         vy_q        <= vga_y;
         vc_q        <= vga_colour;
      end

   always_comb begin
      state_d    = state_q;
      lx_d       = lx_q;
      ly_d       = ly_q;
      lc_d       = lc_q;
      color_d    = color_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      cnt_d      = cnt_q;
      go         = 1'b0;
      reject     = 1'b0;
      plot       = 1'b0;
      vga_x      = vx_q;
      vga_y      = vy_q;
      vga_colour = vc_q;
      case (state_q)
         S_IDLE:
            if (req_q) begin
               if (win_state) state_d = S_OVER;
               else if (cell_occupied) reject = 1'b1;
               else begin
                  state_d = S_COMMIT;
                  lx_d    = cur_x;
                  ly_d    = cur_y;
                  lc_d    = color_q;
               end
            end
         S_COMMIT: begin
            go      = 1'b1;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            cx_d    = '0;
            cy_d    = '0;
            state_d = S_DRAW;
         end
         S_DRAW: begin
            plot       = pix;
            vga_x      = 8'(BOARD_X0 + PITCH * lx_q + cx_q);
            vga_y      = 7'(BOARD_Y0 + PITCH * ly_q + cy_q);
            vga_colour = {3{lc_q}};
            cx_d       = (cx_q == 7'(SPRITE_DIM - 1)) ? 7'd0 : cx_q + 7'd1;
            if (cx_q == 7'(SPRITE_DIM - 1)) begin
               cy_d    = (cy_q == 4'(SPRITE_DIM - 1)) ? 4'd0 : cy_q + 4'd1;
               state_d = (cy_q == 4'(SPRITE_DIM - 1)) ? S_TOGGLE : S_DRAW;
            end
         end
         S_TOGGLE: begin
            color_d = ~color_q;
            cnt_d   = '0;
            state_d = win_state ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            cnt_d   = cnt_q + 8'd1;
            cx_d    = '0;
            cy_d    = '0;
            state_d = (cnt_q == 8'(WIN_DELAY - 1)) ? S_BANNER : S_WAIT;
         end
         S_BANNER: begin
            plot       = pix;
            vga_x      = 8'(TXT_X0 + cx_q);
            vga_y      = 7'(TXT_Y0 + cy_q);
            vga_colour = {3{win_color}};
            cx_d       = (cx_q == 7'(BANNER_W - 1)) ? 7'd0 : cx_q + 7'd1;
            if (cx_q == 7'(BANNER_W - 1)) begin
               cy_d    = (cy_q == 4'(BANNER_H - 1)) ? 4'd0 : cy_q + 4'd1;
               state_d = (cy_q == 4'(BANNER_H - 1)) ? S_OVER : S_BANNER;
            end
         end
         S_OVER: state_d = S_OVER;
      endcase
   end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: self-checking bench with a pixel-level model of the stone and banner.
module tb_move_sequencer;
   import gomoku_pkg::*;

   localparam int X0 = 24, Y0 = 4, P = 16, TX = 2, TY = 2;

   logic       clk = 0, reset = 1, place_req = 0, cell_occupied = 0, win_state = 0, win_color = 0;
   logic [2:0] cur_x = 0, cur_y = 0;
   logic       go, color, reject, plot, busy;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   int   n_cmp = 0, n_bad = 0, blacks = 0;
   logic model_color = 0;
   bit   board [BOARD_DIM][BOARD_DIM];

   typedef struct { int req; int x; int y; int occ; int rej; } vec_t;
   vec_t tbl [9];

   always #5 clk = ~clk;

   move_sequencer dut (
      .clk(clk), .reset(reset), .place_req(place_req), .cur_x(cur_x), .cur_y(cur_y),
      .cell_occupied(cell_occupied), .win_state(win_state), .win_color(win_color),
      .go(go), .color(color), .reject(reject), .plot(plot), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .busy(busy)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Disc of row half-widths 3..7..3 around column 7: 181 pixels in total.
   function automatic logic circ(int r, int c);
      int hw [15] = '{3, 4, 5, 6, 6, 7, 7, 7, 7, 7, 6, 6, 5, 4, 3};
      int d = (c > 7) ? c - 7 : 7 - c;
      return d <= hw[r];
   endfunction

   function automatic logic ban(int r, int c);
      return r == 0 || r == BANNER_H - 1 || c == 0 || c == BANNER_W - 1;
   endfunction

   task step;
      @(negedge clk);
   endtask

   task automatic start_move(input int x, input int y, output logic ok);
      logic occ;
      occ           = board[x][y];
      cur_x         = 3'(x);
      cur_y         = 3'(y);
      cell_occupied = occ;
      place_req     = 1;
      step;
      chk("reject_pulse", reject, occ);
      chk("go_early", go, 0);
      place_req = 0;
      step;
      chk("go_at_2", go, !occ);
      chk("reject_once", reject, 0);
      ok = !occ;
      if (ok) begin
         board[x][y]   = 1;
         cell_occupied = 1;
      end
   endtask

   task automatic run_draw(input int x, input int y, input logic c, input logic win);
      int plots = 0, err = 0, gos = 0, idle = 0, rej = 0;
      int minx = 255, maxx = 0, miny = 127, maxy = 0, ex, ey;
      step;
      chk("settle_busy_plot", {busy, plot, go}, 3'b100);
      for (int i = 0; i < SPRITE_DIM * SPRITE_DIM; i++) begin
         step;
         ex = X0 + P * x + i % SPRITE_DIM;
         ey = Y0 + P * y + i / SPRITE_DIM;
         if (plot !== circ(i / SPRITE_DIM, i % SPRITE_DIM) || vga_x !== ex[7:0] ||
             vga_y !== ey[6:0] || vga_colour !== {3{c}}) err++;
         if (plot === 1'b1) begin
            plots++;
            minx = (int'(vga_x) < minx) ? int'(vga_x) : minx;
            maxx = (int'(vga_x) > maxx) ? int'(vga_x) : maxx;
            miny = (int'(vga_y) < miny) ? int'(vga_y) : miny;
            maxy = (int'(vga_y) > maxy) ? int'(vga_y) : maxy;
         end
         if (go !== 1'b0) gos++;
         if (busy !== 1'b1) idle++;
         if (reject !== 1'b0) rej++;
         place_req     = 1'($urandom_range(0, 1));
         cur_x         = 3'($urandom_range(0, 6));
         cur_y         = 3'($urandom_range(0, 6));
         cell_occupied = board[cur_x][cur_y];
      end
      place_req = 0;
      chk("draw_pixel_err", err, 0);
      chk("draw_plots", plots, 181);
      chk("draw_extra_go", gos, 0);
      chk("draw_not_busy", idle, 0);
      chk("draw_reject", rej, 0);
      chk("draw_minx", minx, X0 + P * x);
      chk("draw_maxx", maxx, X0 + P * x + 14);
      chk("draw_miny", miny, Y0 + P * y);
      chk("draw_maxy", maxy, Y0 + P * y + 14);
      step;
      chk("toggle_busy_plot", {busy, plot}, 2'b10);
      step;
      chk("color_after", color, !c);
      chk("busy_after", busy, win);
   endtask

   task automatic move(input int x, input int y);
      logic ok;
      start_move(x, y, ok);
      if (ok) begin
         if (!model_color) blacks++;
         win_state = (blacks == 5) && !model_color;
         run_draw(x, y, model_color, win_state);
         model_color = ~model_color;
      end else begin
         step;
         chk("reject_stays_idle", {busy, go}, 2'b00);
         chk("reject_color", color, model_color);
      end
   endtask

   initial begin
      int   cnt, err, plots, minx, maxx, miny, maxy, ex, ey;
      logic ok;
      tbl = '{'{0, 3, 3, 1, 0}, '{1, 3, 3, 1, 1}, '{1, 3, 3, 1, 0}, '{0, 3, 3, 1, 0},
              '{1, 3, 3, 1, 1}, '{0, 3, 3, 1, 0}, '{0, 5, 2, 0, 0}, '{1, 3, 3, 1, 1},
              '{0, 3, 3, 1, 0}};

      repeat (2) step;
      chk("reset_outputs", {go, color, reject, plot, busy, vga_x, vga_y, vga_colour}, 0);
      reset = 0;
      step;
      chk("idle_outputs", {go, color, reject, plot, busy, vga_x, vga_y, vga_colour}, 0);

      move(3, 3);

      foreach (tbl[i]) begin
         place_req     = tbl[i].req[0];
         cur_x         = 3'(tbl[i].x);
         cur_y         = 3'(tbl[i].y);
         cell_occupied = tbl[i].occ[0];
         step;
         chk($sformatf("tbl%0d_reject", i), reject, tbl[i].rej);
         chk($sformatf("tbl%0d_go_busy", i), {go, busy}, 2'b00);
         chk($sformatf("tbl%0d_color", i), color, model_color);
      end

      move(6, 6);

      for (int k = 0; k < 60 && blacks < 5; k++)
         if ($urandom_range(0, 3) == 0) move(3, 3);
         else move($urandom_range(0, 6), $urandom_range(0, 6));
      if (blacks < 5) begin
         n_cmp++;
         n_bad++;
         $display("FAIL win_not_reached: got %0d black moves expected 5", blacks);
      end

      err = 0;
      for (int j = 1; j < 250; j++) begin
         step;
         if (busy !== 1'b1 || plot !== 1'b0 || go !== 1'b0) err++;
         place_req = 1'($urandom_range(0, 1));
      end
      place_req = 0;
      chk("wait_phase", err, 0);

      err = 0; plots = 0; minx = 255; maxx = 0; miny = 127; maxy = 0;
      for (int k = 0; k < BANNER_W * BANNER_H; k++) begin
         step;
         ex = TX + k % BANNER_W;
         ey = TY + k / BANNER_W;
         if (plot !== ban(k / BANNER_W, k % BANNER_W) || vga_x !== ex[7:0] ||
             vga_y !== ey[6:0] || vga_colour !== {3{win_color}} || busy !== 1'b1) err++;
         if (plot === 1'b1) begin
            plots++;
            minx = (int'(vga_x) < minx) ? int'(vga_x) : minx;
            maxx = (int'(vga_x) > maxx) ? int'(vga_x) : maxx;
            miny = (int'(vga_y) < miny) ? int'(vga_y) : miny;
            maxy = (int'(vga_y) > maxy) ? int'(vga_y) : maxy;
         end
      end
      chk("banner_err", err, 0);
      chk("banner_plots", plots, 2 * BANNER_W + 2 * (BANNER_H - 2));
      chk("banner_x_range", {minx[7:0], maxx[7:0]}, {8'd2, 8'd69});
      chk("banner_y_range", {miny[7:0], maxy[7:0]}, {8'd2, 8'd6});
      step;
      chk("over_busy_plot", {busy, plot}, 2'b00);
      chk("over_hold_xy", {vga_x, vga_y}, {8'd69, 7'd6});

      cur_x = 0; cur_y = 6; cell_occupied = 0;
      step;
      place_req = 1;
      cnt = 0;
      for (int j = 0; j < 4; j++) begin
         step;
         if (go !== 1'b0 || reject !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) cnt++;
      end
      place_req = 0;
      chk("over_ignores_request", cnt, 0);
      chk("over_color", color, model_color);

      reset = 1;
      #1;
      chk("reset_async_idle", {go, color, busy, vga_x}, 0);
      step;
      reset = 0;
      win_state = 0;
      foreach (board[i, j]) board[i][j] = 0;
      model_color = 0;
      blacks = 0;
      step;
      move(1, 5);
      start_move(4, 2, ok);
      step;
      for (int i = 0; i <= 100; i++) step;
      chk("pre_reset_plot", plot, circ(100 / SPRITE_DIM, 100 % SPRITE_DIM));
      chk("pre_reset_color", color, 1);
      reset = 1;
      #1;
      chk("reset_mid_draw", {plot, go, color, busy}, 0);
      chk("reset_mid_draw_xy", {vga_x, vga_y, vga_colour}, 0);
      step;
      reset = 0;
      step;
      chk("after_reset_idle", {busy, color, plot}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
